// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
package adder_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage

// File: rtl/adder_4bit_full_adder.sv
// Single-bit full adder: one stage of the ripple-carry chain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    sum = x ^ y ^ ci;
    co  = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin, one cycle latency.
// The carry out of the top stage and the carry into it are both kept so
// two's-complement overflow can be taken as their XOR.
module adder_4bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);

  // carry_p0[i] is the carry into stage i; carry_p0[WIDTH] leaves the MSB.
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;

  assign carry_p0[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .x   (a[i]),
      .y   (b[i]),
      .ci  (carry_p0[i]),
      .sum (sum_p0[i]),
      .co  (carry_p0[i+1])
    );
  end

  // Overflow: carry into the MSB disagrees with carry out of the MSB.
  always_comb begin
    ovf_p0 = carry_p0[WIDTH-1] ^ carry_p0[WIDTH];
  end

  // ---- stage boundary p0 -> p1: capture result, track valid ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s        <= sum_p0;
        cout     <= carry_p0[WIDTH];
        overflow <= ovf_p0;
      end
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Directed self-checking bench for adder_4bit with an exhaustive sweep.
module tb_adder_4bit;
  import adder_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid;
  operand_t a;
  operand_t b;
  logic     cin;
  operand_t s;
  logic     cout;
  logic     overflow;
  logic     out_valid;

  int n_assert = 0;
  int n_fail   = 0;

  adder_4bit #(.WIDTH(ADDER_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock one edge, then settle past the edge before sampling.
  task automatic drive(input logic r, input logic v, input logic [3:0] ia,
                       input logic [3:0] ib, input logic ic);
    rst      = r;
    in_valid = v;
    a        = ia;
    b        = ib;
    cin      = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ev);
    check({tag, ".s"},         {4'h0, s},         {4'h0, es});
    check({tag, ".cout"},      {7'h0, cout},      {7'h0, ec});
    check({tag, ".overflow"},  {7'h0, overflow},  {7'h0, eo});
    check({tag, ".out_valid"}, {7'h0, out_valid}, {7'h0, ev});
  endtask

  initial begin
    logic [3:0] sa, sb;
    logic       sc;
    logic [4:0] esum;
    logic       eovf;

    rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;

    // Reset held two cycles with live operands present
    drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    check_all("reset1", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    check_all("reset2", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
    check_all("idle_after_reset", 4'h0, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    check_all("0+0+0", 4'b0000, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'b0001, 4'b0010, 1'b0);
    check_all("1+2+0", 4'b0011, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'b1100, 4'b1110, 1'b0);
    check_all("C+E+0", 4'b1010, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
    check_all("0+0+1", 4'b0001, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 4'b0011, 1'b1);
    check_all("0+3+1", 4'b0100, 1'b0, 1'b0, 1'b1);

    // Carry propagation and overflow
    drive(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1);
    check_all("F+0+1", 4'b0000, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    check_all("7+1+0", 4'b1000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
    check_all("F+F+1", 4'b1111, 1'b1, 1'b0, 1'b1);

    // Hold while in_valid is low
    drive(1'b0, 1'b1, 4'b0001, 4'b0010, 1'b0);
    check_all("hold_load", 4'b0011, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
      check_all("hold", 4'b0011, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the same cycle as a valid operand set
    drive(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    check_all("pre_reset", 4'b1000, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 4'b1100, 4'b1110, 1'b0);
    check_all("reset_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    check_all("after_reset_mid", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Exhaustive sweep, one operand set per cycle
    for (int i = 0; i < 512; i++) begin
      sa = i[3:0];
      sb = i[7:4];
      sc = i[8];
      esum = {1'b0, sa} + {1'b0, sb} + {4'b0000, sc};
      eovf = (sa[3] == sb[3]) && (esum[3] != sa[3]);
      drive(1'b0, 1'b1, sa, sb, sc);
      check_all("sweep", esum[3:0], esum[4], eovf, 1'b1);
    end

    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    check({"sweep_end", ".out_valid"}, {7'h0, out_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_4bit.md
Name: adder_4bit

Overview:
Registered 4-bit ripple-carry adder computing {cout, s} = a + b + cin. Operands are sampled on a clock edge when in_valid is high, and the result is presented one cycle later. It is a leaf arithmetic block for datapaths that need a carry-in/carry-out chainable adder with a simple valid handshake.

Parameters:
- WIDTH, 4, operand and sum width in bits. The block is verified at 4; any WIDTH >= 1 must elaborate.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- s  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out, MSB stage
- overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  s/cout/overflow hold a new result this cycle

Behaviour:
- Arithmetic: {cout, s} = a + b + cin, computed as an unsigned (WIDTH+1)-bit sum with no truncation beyond the WIDTH+1 bits.
- The core is a combinational ripple chain of WIDTH full-adder stages. Stage 0 takes cin. Stage i takes the carry from stage i-1. cout is the carry out of stage WIDTH-1.
- Latency is exactly 1 cycle. If in_valid=1 at edge N, then s, cout and overflow are updated at edge N, and out_valid=1 during cycle N+1.
- If in_valid=0 at an edge:
  - s, cout and overflow hold their previous values.
  - out_valid goes to 0 at that edge.
- There is no backpressure. A new operand set may be accepted every cycle, and back-to-back valid inputs produce back-to-back valid outputs.
- Reset: if rst=1 at a rising edge, then s=0, cout=0, overflow=0 and out_valid=0. rst has priority over in_valid.
- Reset mid-operation: an operand set accepted in the cycle rst is asserted is discarded and never appears on the outputs.
- Boundary values:
  - All-ones + all-ones + 1 gives s=all-ones, cout=1.
  - 0 + 0 + 0 gives s=0, cout=0.
  - Carry-in must fully propagate: all-ones + 0 + 1 gives s=0, cout=1.
- X-propagation: outputs are defined only when in_valid=1. No protection against X on a, b or cin is required.
- The block has no combinational path from inputs to outputs.

Decomposition:
- Shared package adder_pkg:
  - constant ADDER_WIDTH = 4
  - typedef operand_t = logic [ADDER_WIDTH-1:0]
- Sub-module full_adder: inputs x, y, ci; outputs sum = x^y^ci, co = majority(x, y, ci). It is instantiated WIDTH times via a generate loop.
- The top module holds the carry chain wiring, overflow derivation and output/valid registers.

Test Plan:
- Reset: rst=1 for 2 cycles with a=4'hF, b=4'hF, cin=1, in_valid=1 -> s=0000, cout=0, overflow=0, out_valid=0. Then deassert rst and keep in_valid low for one cycle -> outputs remain 0.
- Stream of one valid operand set per cycle, checked 1 cycle later:
  - cin=0, a=0000, b=0000 -> s=0000, cout=0
  - cin=0, a=0001, b=0010 -> s=0011, cout=0
  - cin=0, a=1100, b=1110 -> s=1010, cout=1, overflow=0
  - cin=1, a=0000, b=0000 -> s=0001, cout=0
  - cin=1, a=0000, b=0011 -> s=0100, cout=0
- Carry propagation and overflow:
  - a=1111, b=0000, cin=1 -> s=0000, cout=1
  - a=0111, b=0001, cin=0 -> s=1000, cout=0, overflow=1
- Hold behaviour: after a valid 0001+0010, drive in_valid=0 with a=1111, b=1111 for 3 cycles -> s stays 0011 and out_valid=0 for those cycles.
- Reset mid-stream: apply valid 1100+1110 with rst=1 in the same cycle -> next cycle s=0000, cout=0, out_valid=0. The result 1010 never appears.
- Exhaustive sweep: all 512 combinations of a, b, cin, issued back-to-back -> every output matches a+b+cin one cycle later, with out_valid continuously 1.
